// File: rtl/sevenseg_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: digit positions and
// active-high segment patterns, bit order {g,f,e,d,c,b,a} (bit 0 = a).
package sevenseg_scan_pkg;

  typedef enum logic [1:0] {
    POS_ONEMIN = 2'd0,
    POS_TENMIN = 2'd1,
    POS_ONEHR  = 2'd2,
    POS_TENHR  = 2'd3
  } digit_pos_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/sevenseg_scan_bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-high segments.
// Non-decimal codes decode to a dark digit.
module bcd_to_7seg
  import sevenseg_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 4-digit seven-segment driver with blinking colon on the
// ones-hour decimal point. All outputs are registered.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int BLANK_LEAD  = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic [3:0] tenhr,
  input  logic [3:0] onehr,
  input  logic [3:0] tenmin,
  input  logic [3:0] onemin,
  input  logic       sec_pulse,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int         CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD);
  localparam logic       POL       = (ACTIVE_LOW != 0);

  logic [CW-1:0] cnt;
  digit_pos_t    idx;
  logic          fresh;
  logic          colon_q;
  logic [3:0]    snap_tenhr, snap_onehr, snap_tenmin, snap_onemin;

  logic          wrap;
  logic          guard;
  logic [3:0]    digit;
  logic [6:0]    seg_hi;
  logic [3:0]    an_hi;
  logic          dp_hi;

  assign wrap  = (cnt == LAST);
  assign guard = (cnt < GUARD_END);

  always_comb begin
    digit = snap_onemin;
    case (idx)
      POS_ONEMIN: digit = snap_onemin;
      POS_TENMIN: digit = snap_tenmin;
      POS_ONEHR:  digit = snap_onehr;
      POS_TENHR:  digit = snap_tenhr;
      default:    digit = snap_onemin;
    endcase
  end

  bcd_to_7seg u_dec (
    .digit (digit),
    .seg   (seg_hi)
  );

  // Leading-zero blanking only suppresses the anode; cathodes still follow the decode.
  always_comb begin
    an_hi = '0;
    if (!guard && !((BLANK_LEAD != 0) && (idx == POS_TENHR) && (snap_tenhr == 4'd0)))
      an_hi[idx] = 1'b1;
    dp_hi = (idx == POS_ONEHR) && colon_q && !guard;
  end

  // fresh forces one snapshot load on the first clock after reset release.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= POS_ONEMIN;
      fresh       <= 1'b1;
      colon_q     <= 1'b0;
      snap_tenhr  <= '0;
      snap_onehr  <= '0;
      snap_tenmin <= '0;
      snap_onemin <= '0;
    end else begin
      fresh <= 1'b0;
      cnt   <= wrap ? '0 : cnt + 1'b1;
      if (wrap)
        idx <= digit_pos_t'(idx + 2'd1);
      if (fresh || (wrap && idx == POS_TENHR)) begin
        snap_tenhr  <= tenhr;
        snap_onehr  <= onehr;
        snap_tenmin <= tenmin;
        snap_onemin <= onemin;
      end
      if (sec_pulse)
        colon_q <= ~colon_q;
    end
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      an  <= {4{POL}};
      seg <= {7{POL}};
      dp  <= POL;
    end else begin
      an  <= an_hi ^ {4{POL}};
      seg <= seg_hi ^ {7{POL}};
      dp  <= dp_hi ^ POL;
    end
  end

endmodule
